// File: rtl/ps2_scan_receiver.sv
// rtl/ps2_scan_receiver.sv - PS/2 keyboard frame receiver with prefix folding and FWFT code FIFO
//
// Receives 11-bit PS/2 frames (start, 8 data LSB first, odd parity, stop) sampled on
// H2L_Sig pulses. E0/F0 prefix bytes are folded into Ext/Break flags on the next
// scan code, which is then queued in a first-word-fall-through FIFO.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   H2L_Sig           one-cycle pulse per PS/2 clock falling edge
//   PS2_Data_Pin_In   synchronised PS/2 data line
//   Key_Code/Ext/Break  FIFO head entry (zero while empty)
//   Key_Valid         FIFO not empty
//   Key_Ack           pop the head entry (ignored while empty)
//   Fifo_Count        current number of queued entries
//   Err_Parity        one-cycle pulse on bad parity
//   Err_Frame         one-cycle pulse on bad start, bad stop or timeout
//   Overflow          one-cycle pulse when a decoded code is dropped (FIFO full)

module ps2_scan_receiver #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          H2L_Sig,
    input  logic                          PS2_Data_Pin_In,
    output logic [7:0]                    Key_Code,
    output logic                          Key_Ext,
    output logic                          Key_Break,
    output logic                          Key_Valid,
    input  logic                          Key_Ack,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
    output logic                          Err_Parity,
    output logic                          Err_Frame,
    output logic                          Overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic           stop_q, stop_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           ext_q, ext_d;
    logic           brk_q, brk_d;
    logic           err_par_q, err_par_d;
    logic           err_frm_q, err_frm_d;
    logic           ovf_q, ovf_d;

    logic           push;
    logic [9:0]     push_data;

    logic [9:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           pop;
    logic           full;
    logic           wr_en;
    logic [9:0]     head;

    // Frame FSM: next state, datapath and prefix handling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        tmo_d     = tmo_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        err_par_d = 1'b0;
        err_frm_d = 1'b0;
        push      = 1'b0;
        push_data = {ext_q, brk_q, shift_q};

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (H2L_Sig) begin
                    if (!PS2_Data_Pin_In) begin
                        state_d = S_DATA;
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                    end else begin
                        err_frm_d = 1'b1;
                    end
                end
            end

            S_DATA, S_PARITY, S_STOP: begin
                // A sampling edge always wins over an expiring timeout in the same cycle
                if (H2L_Sig) begin
                    tmo_d = '0;
                    if (state_q == S_DATA) begin
                        shift_d[cnt_q] = PS2_Data_Pin_In;
                        cnt_d          = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end
                    end else if (state_q == S_PARITY) begin
                        par_d   = PS2_Data_Pin_In;
                        state_d = S_STOP;
                    end else begin
                        stop_d  = PS2_Data_Pin_In;
                        state_d = S_CHECK;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = S_IDLE;
                    err_frm_d = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                    shift_d   = 8'h00;
                    cnt_d     = 3'd0;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_CHECK: begin
                state_d = S_IDLE;
                tmo_d   = '0;
                if (!stop_q) begin
                    err_frm_d = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else if (!(^{shift_q, par_q})) begin
                    // Odd parity: data plus parity must contain an odd number of ones
                    err_par_d = 1'b1;
                    ext_d     = 1'b0;
                    brk_d     = 1'b0;
                end else if (shift_q == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO control: an ack frees a slot in the same cycle, so push while full plus ack succeeds
    always_comb begin
        pop      = Key_Ack && (count_q != '0);
        full     = (count_q == CW'(FIFO_DEPTH));
        wr_en    = push && (!full || pop);
        ovf_d    = push && full && !pop;
        rd_ptr_d = pop   ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            ovf_q     <= 1'b0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            err_par_q <= err_par_d;
            err_frm_q <= err_frm_d;
            ovf_q     <= ovf_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the count qualifies every read
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign Key_Valid  = (count_q != '0);
    assign Key_Code   = Key_Valid ? head[7:0] : 8'h00;
    assign Key_Break  = Key_Valid ? head[8]   : 1'b0;
    assign Key_Ext    = Key_Valid ? head[9]   : 1'b0;
    assign Fifo_Count = count_q;
    assign Err_Parity = err_par_q;
    assign Err_Frame  = err_frm_q;
    assign Overflow   = ovf_q;

endmodule

// File: doc/ps2_scan_receiver.md
# ps2_scan_receiver

Parametrised PS/2 keyboard frame receiver that replaces the single-byte decoder. It checks the start bit, odd parity, the stop bit and an inter-edge timeout. It folds the E0 (extended) and F0 (break) prefixes into flags attached to the following scan code. Decoded codes go into a first-word-fall-through FIFO with a valid/ack handshake toward the UART/Modbus transmit path. It sits between the PS/2 clock edge detector, which supplies `H2L_Sig`, and the transmit controller.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: number of FIFO entries; power of two, minimum 2.
- `TIMEOUT_CYC`, default 50000: number of CLK cycles without `H2L_Sig`, while a frame is in progress, that aborts the frame; minimum 16.

Ports (one clock; reset is asynchronous and active-high):
- `CLK` input, 1 bit: system clock.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `H2L_Sig` input, 1 bit: one-cycle pulse marking a falling edge of the PS/2 clock.
- `PS2_Data_Pin_In` input, 1 bit: PS/2 data line, already synchronised.
- `Key_Code` output, 8 bits: scan code at the FIFO head.
- `Key_Ext` output, 1 bit: head entry was preceded by E0.
- `Key_Break` output, 1 bit: head entry was preceded by F0.
- `Key_Valid` output, 1 bit: FIFO is not empty.
- `Key_Ack` input, 1 bit: pops the head entry; ignored when `Key_Valid` is 0.
- `Fifo_Count` output, $clog2(FIFO_DEPTH)+1 bits: current number of entries.
- `Err_Parity` output, 1 bit: one-cycle pulse when a frame has bad parity.
- `Err_Frame` output, 1 bit: one-cycle pulse for a bad start bit, bad stop bit or timeout.
- `Overflow` output, 1 bit: one-cycle pulse when a code is dropped because the FIFO is full.

## Operation
- Reset values: all outputs 0, FIFO empty, both prefix flags cleared, FSM in IDLE, timeout counter 0.
- Frame format: start bit (0), 8 data bits LSB first, odd parity bit, stop bit (1). Each bit is sampled on a cycle where `H2L_Sig`=1.
- FSM states:
  - IDLE: on `H2L_Sig`, data=0 moves to DATA with the bit counter at 0. Data=1 raises `Err_Frame` and stays in IDLE.
  - DATA: on each `H2L_Sig`, the bit is shifted into `shift[cnt]`. After the 8th bit the FSM moves to PARITY.
  - PARITY: on `H2L_Sig`, the parity bit is latched and the FSM moves to STOP.
  - STOP: on `H2L_Sig`, the stop bit is latched and the FSM moves to CHECK.
  - CHECK (exactly one cycle, then back to IDLE), checks in priority order:
    - Stop bit = 0: pulse `Err_Frame`.
    - Otherwise, XOR of the 8 data bits and the parity bit = 0: pulse `Err_Parity`.
    - Otherwise, byte 0xE0: set `ext_pend`.
    - Otherwise, byte 0xF0: set `brk_pend`.
    - Otherwise: push {`ext_pend`, `brk_pend`, byte} and clear both pending flags.
  - Either error also clears both pending flags and pushes nothing.
- Timeout:
  - The counter runs in DATA, PARITY and STOP, and is cleared on every `H2L_Sig` and in IDLE.
  - When it reaches `TIMEOUT_CYC`-1: go to IDLE, pulse `Err_Frame`, clear the pending flags and the partial byte.
- FIFO handling:
  - Push when full: entry dropped, `Overflow` pulses, FIFO contents unchanged, pending flags still cleared.
  - Push and `Key_Ack` in the same cycle while full: both take effect, no overflow, count unchanged.
  - Push and ack in the same cycle while empty: no pop occurs; the entry is written and count becomes 1.
  - Read and write pointers wrap modulo `FIFO_DEPTH`. Count is held separately so that full and empty are distinguishable.
- `RST` asserted mid-frame or mid-handshake: everything returns to reset values immediately. Buffered codes are lost.

## Timing
- Let T be the clock edge that samples the stop bit. CHECK executes at edge T+1.
- After edge T+1: the error pulse is high for exactly one cycle, or `Key_Valid`=1 with the new entry visible. If the FIFO was empty, the new entry is the head. Worst-case latency from the stop-bit `H2L_Sig` to the result is 2 cycles.
- `Key_Ack` sampled at edge K: the next entry, or `Key_Valid`=0, is visible after edge K. `Key_Code`, `Key_Ext` and `Key_Break` hold steady while `Key_Valid`=1 and no ack is given.
- An `H2L_Sig` arriving in the CHECK cycle is treated as a start-bit sample in IDLE on the following cycle only if it is still asserted. Sources must space edges at least 2 cycles apart, which PS/2 always satisfies.
- The pending flags persist across frames indefinitely; only a completed code, an error, a timeout or reset clears them.

## Test plan
- Make code: send 0x1C with parity 0 → one entry with `Key_Code`=0x1C, `Key_Ext`=0, `Key_Break`=0, `Fifo_Count`=1. `Key_Ack` → `Key_Valid`=0.
- Prefix chain: send E0 (parity 0), F0 (parity 1), 0x75 (parity 0) → exactly one entry, 0x75 with Ext=1 and Break=1. A following 0x1C → Ext=0, Break=0.
- Parity error: send F0 correctly, then 0x1C with parity 1 → `Err_Parity` pulses once, nothing pushed. A following 0x1C → Break=0.
- Timeout: send start bit plus 5 data bits, then idle for `TIMEOUT_CYC` cycles → one `Err_Frame` pulse, FSM in IDLE. The next full 0x75 frame decodes correctly.
- Overflow: with `FIFO_DEPTH`=4 and no ack, send 5 codes 0x11–0x15 → `Overflow` pulses once, `Fifo_Count`=4, pops return 0x11–0x14 in order. Also check ack and push in the same cycle while full → no overflow.
- Reset mid-frame: assert `RST` after 4 data bits with 2 entries queued → all outputs 0 at once. After release, 0x1C decodes normally.
